// File: rtl/axis_filter_pkg.sv
// Shared types and helpers for the AXI-Stream boxcar filter.
// Holds the controller state encoding, the accumulator width rule and the output clamp.
package axis_filter_pkg;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  // A window of 2^max_log2_win full-scale samples fits without overflow.
  function automatic int sum_width(input int sample_w, input int max_log2_win);
    return sample_w + max_log2_win;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/boxcar_history_ram.sv
// Circular sample history: one synchronous write port, one asynchronous read port.
// The asynchronous read maps onto distributed (LUT) RAM.
module boxcar_history_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_boxcar_filter.sv
// Multi-channel moving-average filter with run-time power-of-two window and bypass.
// The running sums are kept up to date in bypass so that re-enabling is transient-free.
module axis_boxcar_filter
  import axis_filter_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int SAMPLE_W     = 24,
  parameter int MAX_LOG2_WIN = 8,
  localparam int WS_W        = $clog2(MAX_LOG2_WIN + 1)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         filter_enable,
  input  logic [WS_W-1:0]              win_sel,
  output logic                         busy,
  input  logic [CHANNELS*SAMPLE_W-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [CHANNELS*SAMPLE_W-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast
);

  localparam int ADDR_W = MAX_LOG2_WIN;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DATA_W = CHANNELS * SAMPLE_W;
  localparam int SUM_W  = sum_width(SAMPLE_W, MAX_LOG2_WIN);

  state_t              state_q, state_d;
  logic [WS_W-1:0]     win_q, win_d, win_clamped;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;

  logic                clearing, accept;
  logic [ADDR_W:0]     win_len;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   hist_rdata;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;
  logic signed [SUM_W:0]       rnd_add;
  logic [SAMPLE_W-1:0] y_ch [CHANNELS];
  logic [DATA_W-1:0]   y_filt;

  always_comb begin
    win_clamped = win_sel;
    if (win_sel > WS_W'(MAX_LOG2_WIN)) win_clamped = WS_W'(MAX_LOG2_WIN);
  end

  assign clearing      = (state_q == CLEAR);
  assign busy          = clearing;
  assign s_axis_tready = (state_q == RUN) && (win_clamped == win_q) && (!m_valid_q || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Oldest sample of the window; at the maximum window this wraps onto wr_ptr itself.
  assign win_len = (ADDR_W + 1)'(1) << win_q;
  assign rd_addr = ADDR_W'({1'b0, wr_ptr_q} - win_len);
  assign rnd_add = (win_q == '0) ? '0 : (SUM_W + 1)'(1) <<< (win_q - WS_W'(1));

  assign ram_we    = clearing || accept;
  assign ram_waddr = clearing ? clr_cnt_q : wr_ptr_q;
  assign ram_wdata = clearing ? '0 : s_axis_tdata;

  boxcar_history_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_hist (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (hist_rdata)
  );

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic signed [SAMPLE_W-1:0] x, old;
    logic signed [SUM_W-1:0]    sum_q, sum_d;
    logic signed [SUM_W:0]      rnd, avg;

    assign x   = s_axis_tdata[gi*SAMPLE_W +: SAMPLE_W];
    assign old = hist_rdata[gi*SAMPLE_W +: SAMPLE_W];

    always_comb begin
      sum_d = sum_q;
      if (clearing) sum_d = '0;
      else if (accept) sum_d = sum_q + SUM_W'(x) - SUM_W'(old);
      rnd = (SUM_W + 1)'(sum_d) + rnd_add;
      avg = rnd >>> win_q;
    end

    always_ff @(posedge clk) begin
      if (!resetn) sum_q <= '0;
      else         sum_q <= sum_d;
    end

    assign y_ch[gi] = SAMPLE_W'(saturate(64'(avg), SAMPLE_W));
  end

  always_comb begin
    y_filt = '0;
    for (int c = 0; c < CHANNELS; c++) y_filt[c*SAMPLE_W +: SAMPLE_W] = y_ch[c];
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    clr_cnt_d = clr_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    if (win_clamped != win_q) begin
      state_d   = CLEAR;
      win_d     = win_clamped;
      clr_cnt_d = '0;
    end else if (clearing) begin
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      wr_ptr_d  = '0;
      if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
  end

  // The output register is independent of CLEAR so a stalled beat is never lost.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = filter_enable ? y_filt : s_axis_tdata;
      m_last_d  = s_axis_tlast;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= CLEAR;
      win_q     <= win_clamped;
      clr_cnt_q <= '0;
      wr_ptr_q  <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      clr_cnt_q <= clr_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_axis_boxcar_filter.sv
// Directed bench for axis_boxcar_filter: a window-sum reference model checks every
// delivered beat, and hand-computed literals pin the model on each scenario.
module tb_axis_boxcar_filter;
  localparam int CH = 2;
  localparam int SW = 24;
  localparam int ML = 8;
  localparam int WS_W = $clog2(ML + 1);
  localparam longint SMAX = (longint'(1) << (SW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (SW - 1));

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic filter_enable = 1'b1;
  logic [WS_W-1:0] win_sel = 4'd2;
  logic busy;
  logic [CH*SW-1:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [CH*SW-1:0] m_tdata;
  logic m_tvalid, m_tready = 1'b1, m_tlast;

  always #5 clk = ~clk;

  axis_boxcar_filter #(.CHANNELS(CH), .SAMPLE_W(SW), .MAX_LOG2_WIN(ML)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .filter_enable (filter_enable),
    .win_sel       (win_sel),
    .busy          (busy),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint chv(input logic [CH*SW-1:0] d, input int c);
    logic signed [SW-1:0] v;
    v = d[c*SW +: SW];
    return longint'(v);
  endfunction

  function automatic int clampw(input int w);
    return (w > ML) ? ML : w;
  endfunction

  // Round-half-up mean of the last 2^k samples, missing samples counting as zero.
  function automatic longint win_avg(input longint h[$], input int k);
    longint s, n, d;
    s = 0;
    d = longint'(1) << k;
    for (int i = 0; i < d; i++) if (i < h.size()) s += h[h.size() - 1 - i];
    n = s + ((k > 0) ? d / 2 : 0);
    if (n >= 0) n = n / d;
    else n = -((-n + d - 1) / d);
    if (n > SMAX) n = SMAX;
    if (n < SMIN) n = SMIN;
    return n;
  endfunction

  typedef struct {
    longint y0;
    longint y1;
    logic   last;
  } beat_t;

  longint hist0[$], hist1[$];
  beat_t  exp_q[$];
  longint rx0[$], rx1[$];
  logic   rxl[$];
  int     win_m = 2;

  // Reference model and output scoreboard, evaluated on every rising edge.
  always @(posedge clk) begin
    beat_t e;
    longint x0, x1;
    if (!resetn) begin
      hist0.delete(); hist1.delete(); exp_q.delete();
      win_m = clampw(int'(win_sel));
    end else begin
      if (m_tvalid && m_tready) begin
        rx0.push_back(chv(m_tdata, 0));
        rx1.push_back(chv(m_tdata, 1));
        rxl.push_back(m_tlast);
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("y_ch0", chv(m_tdata, 0), e.y0);
          chk("y_ch1", chv(m_tdata, 1), e.y1);
          chk("tlast", longint'(m_tlast), longint'(e.last));
        end
      end
      if (clampw(int'(win_sel)) != win_m) begin
        hist0.delete(); hist1.delete();
        win_m = clampw(int'(win_sel));
      end else if (s_tvalid && s_tready) begin
        x0 = chv(s_tdata, 0);
        x1 = chv(s_tdata, 1);
        hist0.push_back(x0);
        hist1.push_back(x1);
        if (hist0.size() > (1 << ML)) begin void'(hist0.pop_front()); void'(hist1.pop_front()); end
        e.y0 = filter_enable ? win_avg(hist0, win_m) : x0;
        e.y1 = filter_enable ? win_avg(hist1, win_m) : x1;
        e.last = s_tlast;
        exp_q.push_back(e);
      end
    end
  end

  // Output stability under backpressure and input stall while the output is blocked.
  logic prev_stall = 1'b0;
  logic [CH*SW-1:0] prev_d;
  logic prev_l;
  always @(negedge clk) begin
    #2;
    if (resetn && prev_stall) begin
      chk("hold_valid", longint'(m_tvalid), 1);
      chk("hold_data", longint'(m_tdata == prev_d), 1);
      chk("hold_last", longint'(m_tlast), longint'(prev_l));
    end
    if (resetn && m_tvalid && !m_tready) chk("stall_s_tready", longint'(s_tready), 0);
    prev_stall = resetn && m_tvalid && !m_tready;
    prev_d = m_tdata;
    prev_l = m_tlast;
  end

  // Called at a falling edge; returns at the falling edge after the beat is accepted.
  task automatic send(input int a, input int b, input bit l);
    bit ok;
    s_tdata = {SW'(b), SW'(a)};
    s_tvalid = 1'b1;
    s_tlast = l;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      #1;
      ok = s_tready;
      @(negedge clk);
      if (ok) break;
    end
    if (!ok) chk("send_timeout", 0, 1);
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, base;
    bit quiet;
    longint exp1 [12];
    exp1 = '{1, 2, 3, 4, 5, 4, 3, 2, 0, 1, 0, -1};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_m_tvalid", longint'(m_tvalid), 0);
    chk("rst_m_tdata", longint'(m_tdata), 0);
    chk("rst_m_tlast", longint'(m_tlast), 0);
    chk("rst_s_tready", longint'(s_tready), 0);
    chk("rst_busy", longint'(busy), 1);
    @(negedge clk);
    resetn = 1'b1;

    // CLEAR length and quiet outputs
    cnt = 0;
    quiet = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (!busy) break;
      cnt++;
      if (s_tready || m_tvalid || m_tdata != '0 || m_tlast) quiet = 1'b0;
      @(negedge clk);
    end
    chk("clear_cycles", cnt, 256);
    chk("clear_outputs_quiet", longint'(quiet), 1);
    chk("ready_after_clear", longint'(s_tready), 1);
    @(negedge clk);

    // Window 4: ramp and round-half-up
    base = rx0.size();
    send(4, 0, 0); send(4, 0, 0); send(4, 0, 0); send(4, 0, 0); send(8, 0, 0);
    send(1, 0, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
    send(2, 0, 0); send(-2, 0, 0); send(-3, 0, 1);
    settle();
    chk("w4_count", rx0.size() - base, 12);
    if (rx0.size() - base == 12)
      for (int i = 0; i < 12; i++) chk($sformatf("w4_out%0d", i), rx0[base + i], exp1[i]);

    // Window 256, full-scale negative then positive on ch1
    win_sel = 4'd8;
    base = rx1.size();
    for (int i = 0; i < 256; i++) send(0, -8388608, i == 255);
    for (int i = 0; i < 256; i++) send(0, 8388607, i == 255);
    settle();
    chk("fs_count", rx1.size() - base, 512);
    if (rx1.size() - base == 512) begin
      chk("fs_first", rx1[base], -32768);
      chk("fs_neg_settled", rx1[base + 255], -8388608);
      chk("fs_turn", rx1[base + 256], -8323072);
      chk("fs_pos_settled", rx1[base + 511], 8388607);
    end

    // Backpressure mid-packet
    base = rx1.size();
    fork
      for (int i = 0; i < 8; i++) send(10 + i, -10 - i, i == 7);
      begin
        repeat (3) @(negedge clk);
        m_tready = 1'b0;
        repeat (5) @(negedge clk);
        m_tready = 1'b1;
      end
    join
    settle();
    chk("bp_count", rx1.size() - base, 8);
    if (rx1.size() - base == 8) begin
      chk("bp_last_ch1", rx1[base + 7], 8126463);
      chk("bp_last_tlast", longint'(rxl[base + 7]), 1);
      chk("bp_mid_tlast", longint'(rxl[base + 6]), 0);
    end

    // Bypass keeps history warm
    win_sel = 4'd3;
    filter_enable = 1'b0;
    base = rx0.size();
    for (int i = 0; i < 10; i++) send(100, 100, 0);
    filter_enable = 1'b1;
    send(100, 100, 1);
    settle();
    chk("byp_count", rx0.size() - base, 11);
    if (rx0.size() - base == 11) begin
      chk("byp_first", rx0[base], 100);
      chk("byp_filtered", rx0[base + 10], 100);
    end

    // Window change with a stalled output beat
    m_tready = 1'b0;
    send(200, 200, 0);
    win_sel = 4'd4;
    repeat (2) @(negedge clk);
    #1;
    chk("wc_busy", longint'(busy), 1);
    chk("wc_held_valid", longint'(m_tvalid), 1);
    chk("wc_held_data", chv(m_tdata, 0), 113);
    @(negedge clk);
    base = rx0.size();
    m_tready = 1'b1;
    send(16, 0, 0); send(16, 0, 0); send(16, 0, 0); send(16, 0, 1);
    settle();
    chk("wc_count", rx0.size() - base, 5);
    if (rx0.size() - base == 5) begin
      chk("wc_delivered", rx0[base], 113);
      for (int i = 1; i < 5; i++) chk($sformatf("wc_ramp%0d", i), rx0[base + i], i);
    end

    // Reset mid-stream discards the held beat
    m_tready = 1'b0;
    send(7, 7, 1);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    chk("mrst_valid", longint'(m_tvalid), 0);
    chk("mrst_busy", longint'(busy), 1);
    @(negedge clk);
    resetn = 1'b1;
    m_tready = 1'b1;
    base = rx0.size();
    send(50, -50, 1);
    settle();
    chk("mrst_count", rx0.size() - base, 1);
    if (rx0.size() - base == 1) chk("mrst_out", rx0[base], 3);
    chk("no_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
